// File: rtl/apb_gpio_pkg.sv
// apb_gpio_pkg: shared definitions for the APB GPIO slave.
// Register offsets (PADDR[4:0]), APB slave FSM states and the byte-strobe
// mask helper. The interrupt registers only decode when GPIO_IRQ_EN is defined.
package apb_gpio_pkg;

    localparam logic [4:0] OFF_DATA_OUT   = 5'h00;
    localparam logic [4:0] OFF_DIR        = 5'h04;
    localparam logic [4:0] OFF_DATA_IN    = 5'h08;
    localparam logic [4:0] OFF_INT_EN     = 5'h0C;
    localparam logic [4:0] OFF_INT_POL    = 5'h10;
    localparam logic [4:0] OFF_INT_STATUS = 5'h14;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // Expands one PSTRB bit into the bit mask for its byte lane.
    function automatic logic [7:0] byte_mask(input logic strb);
        return {8{strb}};
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: two-flop synchroniser for asynchronous pin inputs.
// With GPIO_IRQ_EN defined, a previous-value flop is added and per-bit
// rise/fall pulses are produced from the synchronised value; without it
// the edge outputs and their flop do not exist.
module gpio_sync_edge #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] sync_val
`ifdef GPIO_IRQ_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`endif
);

    logic [WIDTH-1:0] meta;

    // Two-stage synchroniser; sync_val is safe to use two clocks after a pin change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta     <= '0;
            sync_val <= '0;
        end else begin
            meta     <= pin;
            sync_val <= meta;
        end
    end

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] prev;

    // Remember last synchronised value so edges last exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= '0;
        else     prev <= sync_val;
    end

    assign rise = sync_val & ~prev;
    assign fall = ~sync_val & prev;
`endif

endmodule

// File: rtl/apb_gpio_slave.sv
// apb_gpio_slave: APB register block driving GPIO pins.
// Registered PREADY/PRDATA/PSLVERR are computed one cycle ahead from the
// next FSM state, so with WAIT_STATES=0 the transfer completes in the first
// ACCESS cycle. Writes commit only on the completing cycle.
// Optional feature macro: GPIO_IRQ_EN (interrupt enable/polarity/status
// registers, edge detection and irq_o). Without it irq_o is tied low and the
// interrupt offsets decode as unmapped.
module apb_gpio_slave
    import apb_gpio_pkg::*;
#(
    parameter int PADDR_SIZE  = 32,
    parameter int PDATA_SIZE  = 32,
    parameter int GPIO_WIDTH  = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic [PADDR_SIZE-1:0]   PADDR,
    input  logic                    PWRITE,
    input  logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [PDATA_SIZE-1:0]   PWDATA,
    output logic [PDATA_SIZE-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    input  logic [GPIO_WIDTH-1:0]   gpio_i,
    output logic [GPIO_WIDTH-1:0]   gpio_o,
    output logic [GPIO_WIDTH-1:0]   gpio_oe,
    output logic                    irq_o
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

    apb_state_t state, state_nxt;
    logic [3:0] wait_cnt, wait_nxt;
    logic       ready_nxt, err_nxt, access_err, mapped, wr_ok;
    logic [PDATA_SIZE-1:0] rdata_nxt, wmask;
    logic [GPIO_WIDTH-1:0] wmask_g, wdata_g, rd_val, data_in;
    logic [4:0] offs;
    logic       unused_addr;

    // Only the low five address bits select a register.
    assign offs        = PADDR[4:0];
    assign unused_addr = ^PADDR[PADDR_SIZE-1:5];

    for (genvar b = 0; b < PDATA_SIZE/8; b++) begin : g_mask
        assign wmask[b*8 +: 8] = byte_mask(PSTRB[b]);
    end

    assign wmask_g = wmask[GPIO_WIDTH-1:0];
    assign wdata_g = PWDATA[GPIO_WIDTH-1:0];

`ifdef GPIO_IRQ_EN
    logic [GPIO_WIDTH-1:0] int_en, int_pol, int_status, rise, fall, hit, w1c;

    gpio_sync_edge #(.WIDTH(GPIO_WIDTH)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .pin      (gpio_i),
        .sync_val (data_in),
        .rise     (rise),
        .fall     (fall)
    );
`else
    gpio_sync_edge #(.WIDTH(GPIO_WIDTH)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .pin      (gpio_i),
        .sync_val (data_in)
    );
`endif

    // Address decode and read mux for the currently presented address.
    always_comb begin
        mapped = 1'b1;
        rd_val = '0;
        case (offs)
            OFF_DATA_OUT:   rd_val = gpio_o;
            OFF_DIR:        rd_val = gpio_oe;
            OFF_DATA_IN:    rd_val = data_in;
`ifdef GPIO_IRQ_EN
            OFF_INT_EN:     rd_val = int_en;
            OFF_INT_POL:    rd_val = int_pol;
            OFF_INT_STATUS: rd_val = int_status;
`endif
            default:        mapped = 1'b0;
        endcase
    end

    assign access_err = (offs[1:0] != 2'b00) || !mapped || (PWRITE && offs == OFF_DATA_IN);

    // FSM state register and access-phase wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Next state. SETUP marks the cycle after a completion; like IDLE it
    // accepts a new setup phase. A select seen with PENABLE already high in
    // IDLE is taken as the setup phase, so it never completes that cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, SETUP: state_nxt = PSEL ? ACCESS : IDLE;
            ACCESS: begin
                if (!PSEL)                      state_nxt = IDLE;
                else if (wait_cnt == WAIT_LAST) state_nxt = SETUP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Look one cycle ahead: if the next cycle is the completing ACCESS cycle,
    // prepare PREADY, PSLVERR and read data so they register into it.
    always_comb begin
        wait_nxt = '0;
        if (state == ACCESS && state_nxt == ACCESS) wait_nxt = wait_cnt + 4'd1;
        ready_nxt = (state_nxt == ACCESS) && (wait_nxt == WAIT_LAST);
        err_nxt   = ready_nxt && access_err;
        rdata_nxt = '0;
        if (ready_nxt && !PWRITE && !access_err) rdata_nxt[GPIO_WIDTH-1:0] = rd_val;
    end

    // Registered APB response; PRDATA falls back to zero after the completing cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            PREADY  <= ready_nxt;
            PSLVERR <= err_nxt;
            PRDATA  <= rdata_nxt;
        end
    end

    assign wr_ok = (state == ACCESS) && PREADY && PSEL && PENABLE && PWRITE && !access_err;

    // Pin-facing registers: byte-masked writes on the completing cycle only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_o  <= '0;
            gpio_oe <= '0;
        end else if (wr_ok) begin
            if (offs == OFF_DATA_OUT) gpio_o  <= (gpio_o  & ~wmask_g) | (wdata_g & wmask_g);
            if (offs == OFF_DIR)      gpio_oe <= (gpio_oe & ~wmask_g) | (wdata_g & wmask_g);
        end
    end

`ifdef GPIO_IRQ_EN
    // Edge of the selected polarity per pin; W1C clear bits from the write.
    assign hit = (rise & int_pol) | (fall & ~int_pol);
    assign w1c = (wr_ok && offs == OFF_INT_STATUS) ? (wdata_g & wmask_g) : '0;

    // Interrupt registers; a new edge beats a simultaneous clear of the same bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_en     <= '0;
            int_pol    <= '0;
            int_status <= '0;
            irq_o      <= 1'b0;
        end else begin
            if (wr_ok && offs == OFF_INT_EN)  int_en  <= (int_en  & ~wmask_g) | (wdata_g & wmask_g);
            if (wr_ok && offs == OFF_INT_POL) int_pol <= (int_pol & ~wmask_g) | (wdata_g & wmask_g);
            int_status <= (int_status & ~w1c) | hit;
            irq_o      <= |(int_status & int_en);
        end
    end
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: doc/apb_gpio_slave.md
# apb_gpio_slave

APB slave register block that consumes the transactions carried on the APB interface and drives the GPIO pins of the design under test. It decodes PADDR, applies PSTRB-qualified writes to a small GPIO register file, returns read data with a configurable number of wait states, and flags protocol-level errors on PSLVERR. Input pins are synchronised and edge-detected to raise an optional interrupt.

## Interface
- PADDR_SIZE, 32, APB address width
- PDATA_SIZE, 32, APB data width (multiple of 8)
- GPIO_WIDTH, 32, number of pins (1..PDATA_SIZE); register bits above GPIO_WIDTH read 0, writes ignored
- WAIT_STATES, 0, PREADY-low cycles inserted in ACCESS (0..15)

- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- PSEL  in  1  slave select
- PENABLE  in  1  access phase
- PADDR  in  PADDR_SIZE  byte address
- PWRITE  in  1  1=write
- PSTRB  in  PDATA_SIZE/8  write byte strobes
- PWDATA  in  PDATA_SIZE  write data
- PRDATA  out  PDATA_SIZE  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  transfer error, valid with PREADY
- gpio_i  in  GPIO_WIDTH  asynchronous pin inputs
- gpio_o  out  GPIO_WIDTH  pin output values
- gpio_oe  out  GPIO_WIDTH  pin output enables (1=drive)
- irq_o  out  1  level interrupt

## Operation
- FSM: IDLE -> SETUP on PSEL&!PENABLE; SETUP -> ACCESS next cycle; ACCESS holds until wait counter reaches WAIT_STATES, then completes -> SETUP if PSEL still high with PENABLE low next cycle, else IDLE. PSEL&PENABLE seen in IDLE -> treated as SETUP (no completion that cycle).
- Register map (PADDR[4:0], word aligned, upper bits ignored): 0x00 DATA_OUT RW; 0x04 DIR RW (1=output); 0x08 DATA_IN RO; 0x0C INT_EN RW; 0x10 INT_POL RW (1=rising, 0=falling); 0x14 INT_STATUS W1C.
- Writes commit only on the completing ACCESS cycle; each PSTRB bit gates its byte.
- PSLVERR=1 for: PADDR[1:0]!=0, unmapped offset, write to DATA_IN. Errored writes change no state; errored reads return PRDATA=0.
- gpio_o = DATA_OUT, gpio_oe = DIR, both directly from flops.
- DATA_IN = gpio_i through two-flop synchroniser.

## Timing
- Reset: FSM IDLE, PRDATA=0, PREADY=0, PSLVERR=0, all registers 0, gpio_o=0, gpio_oe=0, irq_o=0, synchroniser flops 0.
- PREADY=0 outside completing cycle; high exactly one cycle per transfer, WAIT_STATES+1 cycles after ACCESS entry for wait 0 case: PREADY high in first ACCESS cycle.
- PRDATA/PSLVERR registered, valid in the PREADY cycle, PRDATA returns to 0 next cycle.
- Register write visible on gpio_o/gpio_oe the cycle after completion.
- gpio_i to DATA_IN: 2 cycles; to INT_STATUS bit: 3 cycles; to irq_o: 4 cycles.
- Same-cycle W1C clear and new edge on one bit: set wins.
- PSEL dropped mid-ACCESS: abort, IDLE, no commit, PREADY stays 0.
- Asynchronous rst mid-transfer: immediate return to reset values; no partial write.

## Configuration
- GPIO_IRQ_EN defined: INT_EN, INT_POL, INT_STATUS, edge detect, irq_o = registered |(INT_STATUS & INT_EN).
- Undefined: those registers unmapped (access -> PSLVERR), irq_o tied 0, no edge-detect flops.

## Structure
- Package apb_gpio_pkg: register offset localparams, FSM state enum (IDLE, SETUP, ACCESS), PSTRB byte-mask function.
- Sub-module gpio_sync_edge: two-flop synchroniser plus previous-value flop, outputs synchronised value and rise/fall pulses per bit.

## Test plan
- Reset then read all offsets -> PRDATA=0, PSLVERR=0 each, PREADY exactly one cycle per transfer.
- Write DATA_OUT=0xA5A5_A5A5 with PSTRB=4'b0101, DIR=0xFFFF_FFFF -> gpio_o=0x00A5_00A5, gpio_oe all 1, readback matches.
- WAIT_STATES=3, read DIR -> PREADY high on 4th ACCESS cycle, PRDATA valid only then.
- Write DATA_IN, read 0x18, read 0x02 -> PSLVERR=1 each, PRDATA=0, no register change.
- GPIO_IRQ_EN: INT_EN=1, INT_POL=1, gpio_i[0] 0->1 -> INT_STATUS=1 after 3 cycles, irq_o=1 after 4; write INT_STATUS=1 -> irq_o=0; W1C coincident with new edge -> bit stays 1.
- Assert rst during ACCESS of write DATA_OUT=0xFF -> gpio_o=0, PREADY=0, FSM IDLE; next transfer completes normally.
